// File: rtl/bcd_sci_counter_pkg.sv
// Shared digit codes and helpers for the BCD scientific-notation counter.
// BCD_E is the code the display path places in the 'E' position.
package bcd_sci_counter_pkg;

  localparam logic [3:0] BCD_0 = 4'h0;
  localparam logic [3:0] BCD_9 = 4'h9;
  localparam logic [3:0] BCD_E = 4'hE;

  function automatic logic [3:0] bcd_succ(input logic [3:0] d);
    return (d == BCD_9) ? BCD_0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the count chain; q_next is exposed so the readout logic
// can register values that stay coherent with the count.
module bcd_digit
  import bcd_sci_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cin,
  input  logic       clr,
  output logic [3:0] q,
  output logic [3:0] q_next,
  output logic       cout
);

  logic [3:0] q_reg;

  always_comb begin
    q_next = q_reg;
    if (clr)
      q_next = BCD_0;
    else if (cin)
      q_next = bcd_succ(q_reg);
  end

  assign cout = cin & (q_reg == BCD_9);
  assign q    = q_reg;

  always_ff @(posedge clk) begin
    if (!rst)
      q_reg <= BCD_0;
    else
      q_reg <= q_next;
  end

endmodule

// File: rtl/bcd_sci_counter.sv
// N-digit BCD event counter with registered mantissa/exponent readout.
// Define BCD_CNT_SAT_EN to saturate at all-9s with a sticky ovf; default wraps.
module bcd_sci_counter
  import bcd_sci_counter_pkg::*;
#(
  parameter int NUM_DIGITS  = 11,
  parameter int MANT_DIGITS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  input  logic                     clr,
  output logic [4*NUM_DIGITS-1:0]  count_bcd,
  output logic [4*MANT_DIGITS-1:0] mant_bcd,
  output logic [3:0]               exp_bcd,
  output logic                     ovf
);

  localparam int EXP_MAX = NUM_DIGITS - MANT_DIGITS;

  generate
    if (NUM_DIGITS < 2 || NUM_DIGITS > 16 || MANT_DIGITS < 1 ||
        MANT_DIGITS >= NUM_DIGITS || EXP_MAX > 9) begin : g_bad_params
      $error("bcd_sci_counter: illegal NUM_DIGITS/MANT_DIGITS combination");
    end
  endgenerate

  logic [NUM_DIGITS:0]         carry;
  logic [NUM_DIGITS-1:0]       nine;
  logic [4*NUM_DIGITS-1:0]     next_flat;
  logic                        all_nine;
  logic                        ovf_hit;
  logic                        ovf_next;
  logic                        ovf_reg;
  logic [4:0]                  msd;
  logic [3:0]                  exp_next;
  logic [3:0]                  exp_reg;
  logic [4*MANT_DIGITS-1:0]    mant_next;
  logic [4*MANT_DIGITS-1:0]    mant_reg;
  logic [4*MANT_DIGITS-1:0]    mant_cand [EXP_MAX+1];

  assign all_nine = &nine;

`ifdef BCD_CNT_SAT_EN
  assign carry[0] = inc & ~all_nine;
`else
  assign carry[0] = inc;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .clk    (clk),
        .rst    (rst),
        .cin    (carry[gi]),
        .clr    (clr),
        .q      (count_bcd[4*gi +: 4]),
        .q_next (next_flat[4*gi +: 4]),
        .cout   (carry[gi+1])
      );
      assign nine[gi] = (count_bcd[4*gi +: 4] == BCD_9);
    end

    for (gi = 0; gi <= EXP_MAX; gi++) begin : g_mant
      assign mant_cand[gi] = next_flat[4*gi +: 4*MANT_DIGITS];
    end
  endgenerate

  // Wrap carries out of the top digit; in saturating mode the inc is blocked instead.
  assign ovf_hit = carry[NUM_DIGITS] | (inc & all_nine);

`ifdef BCD_CNT_SAT_EN
  assign ovf_next = ~clr & (ovf_reg | ovf_hit);
`else
  assign ovf_next = ~clr & ovf_hit;
`endif

  always_comb begin
    msd = 5'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (next_flat[4*i +: 4] != BCD_0)
        msd = 5'(i);
    exp_next = 4'd0;
    if (msd > 5'(MANT_DIGITS - 1))
      exp_next = 4'(msd - 5'(MANT_DIGITS - 1));
    mant_next = mant_cand[0];
    for (int e = 0; e <= EXP_MAX; e++)
      if (exp_next == 4'(e))
        mant_next = mant_cand[e];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_reg  <= 1'b0;
      exp_reg  <= 4'd0;
      mant_reg <= '0;
    end else begin
      ovf_reg  <= ovf_next;
      exp_reg  <= exp_next;
      mant_reg <= mant_next;
    end
  end

  assign ovf      = ovf_reg;
  assign exp_bcd  = exp_reg;
  assign mant_bcd = mant_reg;

endmodule

// File: tb/tb_bcd_sci_counter.sv
// Directed bench: default 11/2 counter plus a 3/2 instance for wrap/saturation.
module tb_bcd_sci_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inc = 1'b0;
  logic clr = 1'b0;
  logic s_inc = 1'b0;
  logic s_clr = 1'b0;

  logic [43:0] count;
  logic [7:0]  mant;
  logic [3:0]  ex;
  logic        ovf;
  logic [11:0] s_count;
  logic [7:0]  s_mant;
  logic [3:0]  s_ex;
  logic        s_ovf;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bcd_sci_counter #(.NUM_DIGITS(11), .MANT_DIGITS(2)) dut (
    .clk(clk), .rst(rst), .inc(inc), .clr(clr),
    .count_bcd(count), .mant_bcd(mant), .exp_bcd(ex), .ovf(ovf)
  );

  bcd_sci_counter #(.NUM_DIGITS(3), .MANT_DIGITS(2)) dut_s (
    .clk(clk), .rst(rst), .inc(s_inc), .clr(s_clr),
    .count_bcd(s_count), .mant_bcd(s_mant), .exp_bcd(s_ex), .ovf(s_ovf)
  );

  typedef struct {
    logic        rst_n;
    logic        clr;
    logic        inc;
    logic [43:0] cnt;
    logic [7:0]  mant;
    logic [3:0]  ex;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [43:0] to_bcd(input int n);
    logic [43:0] r;
    int v;
    v = n;
    r = '0;
    for (int i = 0; i < 11; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk_big(input string name, input logic [43:0] c, input logic [7:0] m,
                         input logic [3:0] e);
    chk({name, "_count"}, 64'(count), 64'(c));
    chk({name, "_mant"}, 64'(mant), 64'(m));
    chk({name, "_exp"}, 64'(ex), 64'(e));
  endtask

  task automatic chk_small(input string name, input logic [11:0] c, input logic [7:0] m,
                           input logic [3:0] e, input logic o);
    chk({name, "_count"}, 64'(s_count), 64'(c));
    chk({name, "_mant"}, 64'(s_mant), 64'(m));
    chk({name, "_exp"}, 64'(s_ex), 64'(e));
    chk({name, "_ovf"}, 64'(s_ovf), 64'(o));
  endtask

  initial begin
    int n;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 44'h0, 8'h00, 4'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 44'h0, 8'h00, 4'd0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 44'h1, 8'h01, 4'd0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 44'h2, 8'h02, 4'd0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 44'h2, 8'h02, 4'd0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 44'h0, 8'h00, 4'd0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 44'h1, 8'h01, 4'd0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 44'h0, 8'h00, 4'd0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      rst = vecs[i].rst_n;
      clr = vecs[i].clr;
      inc = vecs[i].inc;
      tick();
      chk_big($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].mant, vecs[i].ex);
      chk($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].ovf));
      $display("vec %0d: rst=%b clr=%b inc=%b -> count=%0h mant=%0h exp=%0d ovf=%b",
               i, rst, clr, inc, count, mant, ex, ovf);
    end
    clr = 1'b0;

    // 99 -> 100 crosses into exponent 1
    inc = 1'b1;
    repeat (99) tick();
    chk_big("t2_99", 44'h99, 8'h99, 4'd0);
    tick();
    chk_big("t2_100", 44'h100, 8'h10, 4'd1);
    $display("t2: count=%0h mant=%0h exp=%0d", count, mant, ex);

    inc = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;

    n = 0;
    while (n < 12345) begin
      inc = 1'($urandom_range(0, 1));
      tick();
      if (inc) n++;
      chk("t3_count", 64'(count), 64'(to_bcd(n)));
    end
    inc = 1'b0;
    tick();
    chk_big("t3_final", 44'h12345, 8'h12, 4'd3);
    $display("t3: count=%0h mant=%0h exp=%0d", count, mant, ex);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    inc = 1'b1;
    repeat (57) tick();
    chk_big("t4_57", 44'h57, 8'h57, 4'd0);
    clr = 1'b1;
    tick();
    chk_big("t4_clrinc", 44'h0, 8'h00, 4'd0);
    clr = 1'b0;
    repeat (40) tick();
    chk_big("t4_40", 44'h40, 8'h40, 4'd0);
    rst = 1'b0;
    tick();
    chk_big("t4_rst", 44'h0, 8'h00, 4'd0);
    chk("t4_rst_ovf", 64'(ovf), 64'(0));
    $display("t4: count=%0h mant=%0h exp=%0d ovf=%b", count, mant, ex, ovf);
    rst = 1'b1;
    inc = 1'b0;
    tick();

    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    s_inc = 1'b1;
    repeat (999) tick();
    chk_small("s_999", 12'h999, 8'h99, 4'd1, 1'b0);
    tick();
`ifdef BCD_CNT_SAT_EN
    chk_small("sat_1000", 12'h999, 8'h99, 4'd1, 1'b1);
    repeat (3) tick();
    chk_small("sat_more", 12'h999, 8'h99, 4'd1, 1'b1);
    s_inc = 1'b0;
    tick();
    chk_small("sat_hold", 12'h999, 8'h99, 4'd1, 1'b1);
    s_clr = 1'b1;
    tick();
    chk_small("sat_clr", 12'h000, 8'h00, 4'd0, 1'b0);
    s_clr = 1'b0;
`else
    chk_small("wrap_0", 12'h000, 8'h00, 4'd0, 1'b1);
    s_inc = 1'b0;
    tick();
    chk_small("wrap_after", 12'h000, 8'h00, 4'd0, 1'b0);
    s_inc = 1'b1;
    tick();
    chk_small("wrap_next", 12'h001, 8'h01, 4'd0, 1'b0);
    s_inc = 1'b0;
`endif
    $display("t5/6: count=%0h mant=%0h exp=%0d ovf=%b", s_count, s_mant, s_ex, s_ovf);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
